// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// working on operand magnitudes. The FIX state applies the sign correction and
// writes HI/LO.
module muldiv_hilo #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;       // product high half, or partial remainder
  logic [WIDTH-1:0] mq;        // multiplier shifting out, or dividend/quotient
  logic [WIDTH-1:0] opb;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] orig_a;    // raw dividend, returned in HI on divide by zero
  logic             is_div;
  logic             neg_lo;    // negate product, or negate quotient
  logic             neg_hi;    // negate remainder (dividend was negative)
  logic             div_zero;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state == CALC) || (state == FIX);

  // Operand magnitudes and sign flags, used at the accept edge
  always_comb begin
    is_signed = SIGNED_EN && ((op == OP_MULT) || (op == OP_DIV));
    a_neg     = is_signed && src_a[WIDTH-1];
    b_neg     = is_signed && src_b[WIDTH-1];
    mag_a     = a_neg ? -src_a : src_a;
    mag_b     = b_neg ? -src_b : src_b;
  end

  // One shift-add step and one restoring-divide step
  always_comb begin
    add_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    shifted = {acc, mq[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
  end

  // Sign-corrected results written in FIX
  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_lo ? -prod : prod;
    quo_fix  = neg_lo ? -mq : mq;
    rem_fix  = neg_hi ? -acc : acc;
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opb      <= '0;
      orig_a   <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div   <= op[1];
                acc      <= '0;
                mq       <= op[1] ? mag_a : mag_b;
                opb      <= op[1] ? mag_b : mag_a;
                orig_a   <= src_a;
                div_zero <= (src_b == '0);
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= op[1] && a_neg;
                cnt      <= '0;
                state    <= CALC;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (is_div) begin
            acc <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            acc <= add_sum[WIDTH:1];
            mq  <= {add_sum[0], mq[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            if (div_zero) begin
              hi <= orig_a;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: randomized bench for muldiv_hilo (WIDTH=32) checked every
// cycle against a cycle-level behavioural model, plus literal directed cases.
module tb_muldiv_hilo;

  localparam int W = 32;
  localparam bit SIGNED_EN = 1'b1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int nChecks = 0;
  int nFails  = 0;

  // Model state
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_left = 0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;

  muldiv_hilo #(.WIDTH(W), .SIGNED_EN(SIGNED_EN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural result of an arithmetic op, computed with plain integer math
  function automatic void compute(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
    logic   sgn;
    longint sa;
    longint sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sgn = SIGNED_EN && (o == 3'd0 || o == 3'd2);
    sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (o[1] == 1'b0) begin
      p  = 64'(sa * sb);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == '0) begin
      eh = a;
      el = '1;
    end else begin
      q  = 64'(sa / sb);
      r  = 64'(sa % sb);
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  // Behavioural model: accept when idle, result appears WIDTH+1 edges later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_hi   = p_hi;
          m_lo   = p_lo;
        end
        m_left--;
      end else if (start) begin
        if (op <= 3'd3) begin
          compute(op, src_a, src_b, p_hi, p_lo);
          m_busy = 1'b1;
          m_left = W + 1;
        end else if (op == 3'd4) begin
          m_hi = src_a;
        end else if (op == 3'd5) begin
          m_lo = src_a;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  task automatic waitDone(input string name, output int busyCycles);
    bit ok;
    ok = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      @(negedge clk);
    end
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("[TB] FAIL %s timeout: got no done, expected done within 200 cycles", name);
    end
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  bc;
    bit  sawDone;
    $display("[TB] start");
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // MULTU max x max, with busy length
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("multu max", bc);
    checkOutput("multu busy cycles", 32'(bc), 32'd33);
    checkOutput("multu max hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu max lo", lo, 32'h0000_0001);

    applyStimulus(3'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    waitDone("mult -3x5", bc);
    checkOutput("mult -3x5 hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult -3x5 lo", lo, 32'hFFFF_FFF1);

    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    waitDone("div -7/2", bc);
    checkOutput("div -7/2 hi", hi, 32'hFFFF_FFFF);
    checkOutput("div -7/2 lo", lo, 32'hFFFF_FFFD);

    applyStimulus(3'd3, 32'h0000_0007, 32'h0000_0000);
    waitDone("divu 7/0", bc);
    checkOutput("divu 7/0 busy cycles", 32'(bc), 32'd33);
    checkOutput("divu 7/0 hi", hi, 32'h0000_0007);
    checkOutput("divu 7/0 lo", lo, 32'hFFFF_FFFF);

    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div minneg/-1", bc);
    checkOutput("div minneg busy cycles", 32'(bc), 32'd33);
    checkOutput("div minneg hi", hi, 32'h0000_0000);
    checkOutput("div minneg lo", lo, 32'h8000_0000);

    // MTHI in idle, then MTLO ignored during a MULTU
    applyStimulus(3'd4, 32'h1234_5678, 32'h0);
    checkOutput("mthi hi", hi, 32'h1234_5678);
    checkOutput("mthi busy", 32'(busy), 32'd0);
    checkOutput("mthi lo kept", lo, 32'h8000_0000);
    applyStimulus(3'd1, 32'd5, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd5; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    waitDone("multu 5x7", bc);
    checkOutput("multu 5x7 hi", hi, 32'h0);
    checkOutput("multu 5x7 lo", lo, 32'd35);

    // Randomized traffic, start asserted regardless of busy
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      op    = 3'($urandom_range(0, 7));
      src_a = pickOperand();
      src_b = pickOperand();
    end
    @(negedge clk);
    start = 1'b0;
    waitDone("random drain", bc);
    if (busy) waitDone("random drain 2", bc);

    // Reset in the middle of a DIVU
    applyStimulus(3'd4, 32'h0000_AAAA, 32'h0);
    applyStimulus(3'd5, 32'h0000_5555, 32'h0);
    applyStimulus(3'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset hi", hi, 32'h0);
    checkOutput("midreset lo", lo, 32'h0);
    sawDone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("no done after reset", 32'(sawDone), 32'd0);
    applyStimulus(3'd1, 32'd3, 32'd4);
    waitDone("multu 3x4", bc);
    checkOutput("multu 3x4 hi", hi, 32'h0);
    checkOutput("multu 3x4 lo", lo, 32'd12);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
